// File: rtl/ifetch_queue.sv
// ifetch_queue: credit-limited instruction fetch front end with an in-order response FIFO
// and single-cycle redirect flush of buffered and in-flight fetches.
module ifetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc, resp_pc, target;
    logic [31:0]   word_mem [DEPTH];
    logic [31:0]   pc_mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, inflight, discard;
    logic          accept, rsp, push, drop, pop;

    // count + inflight never exceeds DEPTH, so every kept response has a free slot
    always_comb begin
        mem_req    = rst && !redirect && (({1'b0, count} + {1'b0, inflight}) < (CW+1)'(DEPTH));
        mem_addr   = fetch_pc;
        inst_valid = count != '0;
        inst       = word_mem[rd_ptr];
        inst_pc    = pc_mem[rd_ptr];
        target     = redirect_pc & 32'hFFFF_FFFC;
        accept     = mem_req && mem_gnt;
        rsp        = mem_rvalid && inflight != '0;
        drop       = rsp && discard != '0;
        push       = rsp && discard == '0;
        pop        = inst_valid && inst_ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            discard  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                word_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (redirect) begin
            fetch_pc <= target;
            resp_pc  <= target;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= inflight - CW'(rsp);
            discard  <= inflight - CW'(rsp);
        end else begin
            if (accept)
                fetch_pc <= fetch_pc + 32'd4;
            if (push) begin
                word_mem[wr_ptr] <= mem_rdata;
                pc_mem[wr_ptr]   <= resp_pc;
                wr_ptr           <= wr_ptr + AW'(1);
                resp_pc          <= resp_pc + 32'd4;
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count    <= count + CW'(push) - CW'(pop);
            inflight <= inflight + CW'(accept) - CW'(rsp);
            discard  <= discard - CW'(drop);
        end
    end

    assert property (@(posedge clk) disable iff (!rst) mem_rvalid |-> inflight != '0);
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: memory model with programmable latency feeding a PC scoreboard,
// a per-cycle vector table for the back-pressure case, and directed redirect/reset sequences.
module tb_ifetch_queue;
    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 0, rst = 0;
    logic        mem_req, mem_gnt = 0, mem_rvalid = 0, redirect = 0, inst_valid, inst_ready = 0;
    logic [31:0] mem_addr, mem_rdata = 0, redirect_pc = 0, inst, inst_pc;

    always #5 clk = ~clk;

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready)
    );

    typedef struct { logic [31:0] addr; int due; } pend_t;
    typedef struct { bit rdy; bit req; bit valid; logic [31:0] pc; } vec_t;

    pend_t       pend[$];
    logic [31:0] sb[$];
    vec_t        tbl[11];
    int          n_chk = 0, n_fail = 0, cyc = 0, lat = 1, pops = 0;
    logic [31:0] exp_fetch = 0;
    logic        obs_req, obs_valid;
    logic [31:0] obs_pc, obs_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // one clock: drive at negedge, observe 1ns later, state updates at the following posedge
    task automatic step(input bit rdy, input bit gnt, input bit redir = 0, input logic [31:0] rpc = 0);
        logic [31:0] e;
        @(negedge clk);
        inst_ready = rdy;
        mem_gnt = gnt;
        redirect = redir;
        redirect_pc = rpc;
        mem_rvalid = 0;
        mem_rdata = 0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            mem_rvalid = 1;
            mem_rdata = pend[0].addr ^ K;
            void'(pend.pop_front());
        end
        #1;
        obs_req = mem_req;
        obs_valid = inst_valid;
        obs_pc = inst_pc;
        obs_addr = mem_addr;
        if (redir) begin
            chk("redirect_req", mem_req, 0);
            sb.delete();
            exp_fetch = {rpc[31:2], 2'b00};
        end else begin
            if (inst_valid && rdy) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_underflow: got inst_pc %h expected no instruction", inst_pc);
                end else begin
                    e = sb.pop_front();
                    chk("inst_pc", inst_pc, e);
                    chk("inst", inst, e ^ K);
                    pops++;
                end
            end
            if (mem_req && gnt) begin
                chk("mem_addr", mem_addr, exp_fetch);
                pend.push_back('{mem_addr, cyc + lat});
                sb.push_back(exp_fetch);
                exp_fetch += 4;
            end
        end
        cyc++;
    endtask

    task automatic do_reset(input int l);
        rst = 0;
        mem_rvalid = 0;
        mem_rdata = 0;
        mem_gnt = 0;
        redirect = 0;
        inst_ready = 0;
        #1;
        chk("rst_valid", inst_valid, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_inst", inst, 0);
        chk("rst_pc", inst_pc, 0);
        chk("rst_addr", mem_addr, 32'h0);
        pend.delete();
        sb.delete();
        exp_fetch = 32'h0;
        lat = l;
        repeat (2) @(posedge clk);
        #1 rst = 1;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 32'h0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 32'h0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'h0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 32'h0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 32'h0};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 32'h4};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 32'h8};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 32'hC};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 32'h10};

        do_reset(1);
        pops = 0;
        for (int k = 0; k < 20; k++) begin
            step(1, 1);
            chk("t1_valid", obs_valid, k >= 2);
        end
        chk("t1_pops", pops, 18);

        do_reset(1);
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].rdy, 1);
            chk("t2_req", obs_req, tbl[i].req);
            chk("t2_valid", obs_valid, tbl[i].valid);
            if (tbl[i].valid) chk("t2_pc", obs_pc, tbl[i].pc);
        end

        do_reset(3);
        repeat (3) step(0, 1);
        step(0, 0);
        step(0, 1, 1, 32'h103);
        chk("t3_pre_valid", obs_valid, 1);
        chk("t3_pre_pc", obs_pc, 32'h0);
        pops = 0;
        step(1, 1);
        chk("t3_flushed", obs_valid, 0);
        chk("t3_req", obs_req, 1);
        chk("t3_addr", obs_addr, 32'h100);
        repeat (15) step(1, 1);
        chk("t3_progress", pops >= 4, 1);

        do_reset(2);
        repeat (10) step(1, 1);
        step(1, 1, 1, 32'h2001);
        chk("t4_pre_valid", obs_valid, 1);
        pops = 0;
        step(1, 1);
        chk("t4_flushed", obs_valid, 0);
        chk("t4_req", obs_req, 1);
        chk("t4_addr", obs_addr, 32'h2000);
        repeat (10) step(1, 1);
        chk("t4_pops", pops, 8);

        do_reset(1);
        repeat (8) step(1, 1);
        for (int k = 0; k < 5; k++) begin
            step(1, 0);
            chk("t5_req", obs_req, 1);
            chk("t5_addr", obs_addr, 32'h20);
        end
        repeat (6) step(1, 1);

        do_reset(2);
        repeat (10) step(1, 1);
        chk("t6_pre_valid", obs_valid, 1);
        #2;
        do_reset(2);
        pops = 0;
        repeat (12) step(1, 1);
        chk("t6_pops", pops, 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
